// File: rtl/seg_disp_sched.sv
// Round-robin scheduler that time-shares the 8-digit seven-segment driver
// between four requesters, with dwell-based rotation, manual advance and hold.
module seg_disp_sched #(
  parameter int unsigned DWELL = 10_000_000,
  parameter int unsigned CNT_W = 24
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [3:0]   src_req,
  input  logic [255:0] src_data,
  input  logic [3:0]   src_mode,
  input  logic         btn_next,
  input  logic         auto_en,
  input  logic         hold,
  output logic [3:0]   src_grant,
  output logic [63:0]  o_data,
  output logic         o_mode,
  output logic [1:0]   o_idx,
  output logic         o_valid
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t             state;
  logic [1:0]         cur, ptr;
  logic [CNT_W-1:0]   cnt;
  logic               btn_q;
  logic [3:0][63:0]   data_v;

  logic               found;
  logic [1:0]         win;
  logic               drop, expire, press, advance;

  assign data_v = src_data;

  // Search ptr+1 .. ptr+4 (mod 4); the last-granted source is considered last.
  function automatic logic [2:0] arb(input logic [3:0] req, input logic [1:0] p);
    logic [1:0] c;
    logic       f;
    logic [1:0] w;
    f = 1'b0;
    w = p;
    for (int k = 1; k <= 4; k++) begin
      c = p + 2'(k);
      if (!f && req[c]) begin
        f = 1'b1;
        w = c;
      end
    end
    return {f, w};
  endfunction

  always_comb begin
    {found, win} = arb(src_req, ptr);
  end

  assign drop    = ~src_req[cur];
  assign expire  = auto_en && (cnt == LAST);
  assign press   = btn_next & ~btn_q;
  assign advance = drop | expire | press;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cur       <= 2'd0;
      ptr       <= 2'd3;
      cnt       <= '0;
      btn_q     <= 1'b0;
      src_grant <= 4'b0000;
      o_data    <= '1;
      o_mode    <= 1'b1;
      o_idx     <= 2'd0;
      o_valid   <= 1'b0;
    end else begin
      // Button history tracks even under hold so release never fakes an edge.
      btn_q <= btn_next;
      if (!hold) begin
        if (state == SHOW) begin
          o_data  <= data_v[cur];
          o_mode  <= src_mode[cur];
          o_idx   <= cur;
          o_valid <= 1'b1;
        end else begin
          o_data  <= '1;
          o_mode  <= 1'b1;
          o_idx   <= 2'd0;
          o_valid <= 1'b0;
        end
        case (state)
          IDLE: begin
            if (found) begin
              state     <= SHOW;
              cur       <= win;
              ptr       <= win;
              cnt       <= '0;
              src_grant <= 4'b0001 << win;
            end
          end
          SHOW: begin
            if (advance) begin
              if (found) begin
                cur       <= win;
                ptr       <= win;
                cnt       <= '0;
                src_grant <= 4'b0001 << win;
              end else begin
                state     <= IDLE;
                src_grant <= 4'b0000;
              end
            end else if (cnt != LAST) begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Table-driven bench for seg_disp_sched: each row is one clock of stimulus and
// the outputs expected right after that edge, checked through a scoreboard queue.
module tb_seg_disp_sched;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [3:0]   src_req = '0;
  logic [255:0] src_data = '0;
  logic [3:0]   src_mode = '0;
  logic         btn_next = 1'b0;
  logic         auto_en = 1'b0;
  logic         hold = 1'b0;
  logic [3:0]   src_grant;
  logic [63:0]  o_data;
  logic         o_mode;
  logic [1:0]   o_idx;
  logic         o_valid;

  seg_disp_sched #(.DWELL(8), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .src_req(src_req), .src_data(src_data),
    .src_mode(src_mode), .btn_next(btn_next), .auto_en(auto_en), .hold(hold),
    .src_grant(src_grant), .o_data(o_data), .o_mode(o_mode), .o_idx(o_idx),
    .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       btn, aut, hld, dalt;
    logic [3:0] smode;
    logic [3:0] g;
    logic       v;
    logic [1:0] ix;
    logic       md;
    logic       edalt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic [3:0] def_mode = 4'b0101;

  function automatic logic [63:0] dat(input logic [1:0] ix, input logic alt);
    if (ix == 2'd0 && alt) return 64'hDEAD_BEEF_0BAD_F00D;
    return 64'h1111_1111_1111_1111 * (64'(ix) + 64'd1);
  endfunction

  function automatic logic em(input logic v, input logic [1:0] ix);
    return v ? def_mode[ix] : 1'b1;
  endfunction

  function automatic void add(input logic rst, input logic [3:0] req, input logic btn,
                              input logic aut, input logic hld, input logic dalt,
                              input logic [3:0] smode, input logic [3:0] g, input logic v,
                              input logic [1:0] ix, input logic md, input logic edalt);
    vec_t r;
    r.rst = rst; r.req = req; r.btn = btn; r.aut = aut; r.hld = hld; r.dalt = dalt;
    r.smode = smode; r.g = g; r.v = v; r.ix = ix; r.md = md; r.edalt = edalt;
    tbl.push_back(r);
  endfunction

  function automatic void addn(input logic [3:0] req, input logic btn, input logic aut,
                               input logic hld, input logic dalt, input logic [3:0] g,
                               input logic v, input logic [1:0] ix, input logic edalt);
    add(1'b0, req, btn, aut, hld, dalt, def_mode, g, v, ix, em(v, ix), edalt);
  endfunction

  function automatic void addr();
    add(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, def_mode, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
  endfunction

  // Grant order for requests 1011: 0, 1, 3, 0
  function automatic logic [1:0] gi(input int s);
    case (s)
      1: return 2'd1;
      2: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic chk(input string name, input int row, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    vec_t r, e;
    int   s, sp;

    // Rotation: 1011, DWELL=8, each grant held 8 edges, o_idx lags by one
    addr();
    for (int k = 1; k <= 32; k++) begin
      s  = (k - 1) / 8;
      sp = (k - 2) / 8;
      addn(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0, 4'(1 << gi(s)), k > 1, (k > 1) ? gi(sp) : 2'd0, 1'b0);
    end
    // Async reset mid-dwell
    addr();
    // Drop: source 1 then 1001, then all requests fall
    for (int k = 1; k <= 3; k++)
      addn(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, k > 1, (k > 1) ? 2'd1 : 2'd0, 1'b0);
    addn(4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd1, 1'b0);
    for (int k = 5; k <= 11; k++)
      addn(4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
    addn(4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd3, 1'b0);
    addn(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
    addn(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    // Manual advance, held button, saturation, press+expire collapse
    addr();
    addn(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0);
    for (int k = 2; k <= 4; k++)
      addn(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
    addn(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0);
    addn(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);
    addn(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);
    addn(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd1, 1'b0);
    addn(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0);
    addn(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd2, 1'b0);
    for (int k = 11; k <= 22; k++)
      addn(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
    addn(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd3, 1'b0);
    for (int k = 24; k <= 30; k++)
      addn(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
    addn(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0);
    addn(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);
    // Hold: data change and button pulse while frozen, dwell resumes at cnt=3
    addr();
    addn(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0);
    addn(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
    addn(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
    addn(4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
    addn(4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0);
    for (int k = 6; k <= 8; k++)
      addn(4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0);
    for (int k = 9; k <= 13; k++)
      addn(4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1);
    addn(4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1);
    addn(4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1);
    // Sole requester: grant never drops across expiries, mode follows src_mode[2]
    addr();
    add(1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'b0100, 1'b0, 2'd0, 1'b1, 1'b0);
    for (int k = 2; k <= 20; k++) begin
      if (k >= 11 && k <= 14)
        add(1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0);
      else
        add(1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
    end

    for (int n = 0; n < tbl.size(); n++) begin
      r = tbl[n];
      @(negedge clk);
      rstn     = ~r.rst;
      src_req  = r.req;
      btn_next = r.btn;
      auto_en  = r.aut;
      hold     = r.hld;
      src_mode = r.smode;
      for (int i = 0; i < 4; i++)
        src_data[64*i +: 64] = dat(2'(i), r.dalt);
      sb.push_back(r);
      if (r.rst) begin
        #2;
        chk("async_rst_grant", n, 64'(src_grant), 64'h0);
        chk("async_rst_valid", n, 64'(o_valid), 64'h0);
        chk("async_rst_idx", n, 64'(o_idx), 64'h0);
        chk("async_rst_mode", n, 64'(o_mode), 64'h1);
        chk("async_rst_data", n, o_data, 64'hFFFF_FFFF_FFFF_FFFF);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("grant", n, 64'(src_grant), 64'(e.g));
      chk("valid", n, 64'(o_valid), 64'(e.v));
      chk("idx", n, 64'(o_idx), 64'(e.ix));
      chk("mode", n, 64'(o_mode), 64'(e.md));
      chk("data", n, o_data, e.v ? dat(e.ix, e.edalt) : 64'hFFFF_FFFF_FFFF_FFFF);
    end
    chk("scoreboard_empty", 0, 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_disp_sched.md
# seg_disp_sched

Display scheduler that shares the board's 8-digit seven-segment display driver between up to four requesters (e.g. register file probe, PC, bus monitor, status word). Arbitrates round-robin with a programmable dwell time and a manual advance button, and produces the 64-bit data word plus hex/raw mode select consumed by the seven-segment scan driver. It sits between the CPU/debug sources and the display driver inside the board top level.

## Interface
- DWELL, 24'd10_000_000, cycles each source is shown before auto-rotation (≥2)
- CNT_W, 24, width of the dwell counter; DWELL-1 must fit
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- src_req  in  4  per-source display request, level
- src_data  in  256  source i data at [64*i+63:64*i]
- src_mode  in  4  per-source mode: 0 = hex (low 32 bits, 8 nibbles), 1 = raw segment bytes
- btn_next  in  1  manual advance, level; rising edge acts, debounced externally
- auto_en  in  1  1 = rotate on dwell expiry
- hold  in  1  1 = freeze scheduler and display word
- src_grant  out  4  one-hot of source currently displayed, 0 when idle
- o_data  out  64  word to display driver
- o_mode  out  1  mode to display driver
- o_idx  out  2  index of source in o_data
- o_valid  out  1  1 when o_data belongs to a granted source

## Operation
- States: IDLE (no source shown), SHOW (source cur shown).
- Round-robin pointer ptr = last granted index; search order ptr+1, ptr+2, ptr+3, ptr (mod 4); first requesting source wins. Reset ptr = 3, so first grant from reset is the lowest-index requester starting at 0.
- IDLE: if any src_req → SHOW, cur = arbitration winner, cnt = 0. Otherwise stay.
- SHOW, events evaluated each cycle when hold=0:
  - drop: src_req[cur]=0.
  - expire: auto_en=1 and cnt==DWELL-1.
  - press: btn_next rising edge (btn_q registered, reset 0; sampled even when hold=1 so no false edge on hold release).
- Any of drop/expire/press → re-arbitrate (excluding nothing; cur itself is last in order). Winner → cur, ptr, cnt=0. No requester → IDLE.
- If cur is the sole requester, expire/press re-grants cur and clears cnt; no glitch on src_grant.
- Simultaneous events collapse into one advance; never skip two sources in one cycle.
- cnt increments each SHOW cycle without an event; with auto_en=0 it saturates at DWELL-1 (no wrap).
- hold=1: state, cur, ptr, cnt, o_data, o_mode, o_idx, o_valid all frozen; drop/expire/press ignored (press edge lost).
- Display path (hold=0): SHOW → o_data ← src_data[cur], o_mode ← src_mode[cur], o_idx ← cur, o_valid ← 1, updated live every cycle. IDLE → o_data ← 64'hFFFF_FFFF_FFFF_FFFF, o_mode ← 1 (raw, all segments off), o_idx ← 0, o_valid ← 0.
- src_grant is the registered one-hot of cur in SHOW, 0 in IDLE.

## Timing
- Reset (async, any time incl. mid-dwell): state IDLE, ptr 3, cnt 0, btn_q 0, src_grant 0, o_data all-ones, o_mode 1, o_idx 0, o_valid 0. All outputs registered.
- Event seen in cycle t → cur/src_grant updated at edge t+1 → o_data/o_mode/o_idx/o_valid reflect it at edge t+2. o_idx always aligned with o_data.
- IDLE with request asserted in cycle t → src_grant at t+1, o_valid=1 at t+2.
- Dwell: with steady requests and auto_en=1, each source granted exactly DWELL cycles.
- Source data change visible on o_data one cycle later (live, no re-grant needed).

## Test plan
- Reset: rstn low mid-SHOW with cnt≠0 → next sample all outputs at reset values, o_data=64'hFFFF_FFFF_FFFF_FFFF, src_grant=4'b0000.
- Rotation: DWELL=8, auto_en=1, src_req=4'b1011 → grants 0001,0010,1000,0001 each exactly 8 cycles; o_idx 0,1,3,0 lagging grant by 1 cycle.
- Drop: source 1 granted, src_req[1] falls mid-dwell with src_req=4'b1001 → src_grant=1000 next edge, cnt restarts; all requests drop → IDLE, o_valid=0 two edges later.
- Manual: auto_en=0, src_req=4'b1111, three btn_next pulses → grants 0001→0010→0100→1000; no change while button held high; press and expiry in same cycle advance only once.
- Hold: hold=1 during SHOW while src_data changes and btn pulses → o_data, src_grant frozen; after release rotation resumes with unchanged cnt.
- Sole requester: src_req=4'b0100, DWELL=8 → src_grant stays 0100 continuously, o_mode tracks src_mode[2], hex/raw switch visible one cycle after src_mode change.
